// File: rtl/stopwatch_timebase_if.sv
// Button inputs and display/status outputs of the stopwatch time base.
// master drives the keys and observes the display; slave is the time base itself.
interface stopwatch_timebase_if;
    logic        key_run_n;
    logic        key_lap_n;
    logic [23:0] time_bcd;
    logic        running;
    logic        lap_hold;
    logic        tick;
    logic        wrap;

    modport master (
        output key_run_n, key_lap_n,
        input  time_bcd, running, lap_hold, tick, wrap
    );

    modport slave (
        input  key_run_n, key_lap_n,
        output time_bcd, running, lap_hold, tick, wrap
    );
endinterface

// File: rtl/stopwatch_timebase.sv
// Stopwatch time base: debounced run/lap keys, 1/100 s prescaler,
// run/pause/lap control and a six-digit BCD MM:SS.hh counter with lap freeze.
module stopwatch_timebase #(
    parameter int TICK_DIV        = 500000,
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic                clock,
    input  logic                reset,
    stopwatch_timebase_if.slave bus
);
    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
    // Per-digit maximum, most significant digit first: M M : S S . h h
    localparam logic [5:0][3:0] DIGIT_MAX = {4'd5, 4'd9, 4'd5, 4'd9, 4'd9, 4'd9};

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, LAP} state_t;

    // Bit 0 is the run key, bit 1 the lap key.
    logic [1:0]    keys_raw;
    logic [1:0]    sync1_q, sync2_q, level_q, armed_q, press;
    logic [1:0]    sync_valid_q;
    logic [DW-1:0] stable_cnt_q [2];

    state_t           state_q, state_d;
    logic             run_ev, lap_ev, capture, clear, counting, tick_int, carry;
    logic [PW-1:0]    presc_q;
    logic [5:0][3:0]  digits_q, digits_inc, snap_q;
    logic             running_q, lap_hold_q;

    assign keys_raw = {bus.key_lap_n, bus.key_run_n};

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the stability counters are a tiny register array, so they are reset like ordinary flops.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q      <= '1;
            sync2_q      <= '1;
            level_q      <= '1;
            armed_q      <= '0;
            sync_valid_q <= '0;
            stable_cnt_q <= '{default: '0};
        end else begin
            sync1_q      <= keys_raw;
            sync2_q      <= sync1_q;
            sync_valid_q <= {sync_valid_q[0], 1'b1};
            for (int k = 0; k < 2; k++) begin
                // A key only arms once it is seen released after reset.
                if (sync_valid_q[1] && sync2_q[k]) armed_q[k] <= 1'b1;
                if (sync2_q[k] == level_q[k]) begin
                    stable_cnt_q[k] <= '0;
                end else if (stable_cnt_q[k] == DEB_LAST) begin
                    level_q[k]      <= sync2_q[k];
                    stable_cnt_q[k] <= '0;
                end else begin
                    stable_cnt_q[k] <= stable_cnt_q[k] + 1'b1;
                end
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        press = '0;
        for (int k = 0; k < 2; k++)
            press[k] = armed_q[k] & level_q[k] & ~sync2_q[k] & (stable_cnt_q[k] == DEB_LAST);
    end

    assign run_ev = press[0];
    assign lap_ev = press[1] & ~press[0];

    always_comb begin
        state_d = state_q;
        capture = 1'b0;
        clear   = 1'b0;
        case (state_q)
            IDLE:  if (run_ev) state_d = RUN;
            RUN: begin
                if (run_ev) state_d = PAUSE;
                else if (lap_ev) begin
                    state_d = LAP;
                    capture = 1'b1;
                end
            end
            PAUSE: begin
                if (run_ev) state_d = RUN;
                else if (lap_ev) begin
                    state_d = IDLE;
                    clear   = 1'b1;
                end
            end
            LAP: begin
                if (run_ev) state_d = PAUSE;
                else if (lap_ev) state_d = RUN;
            end
            default: state_d = IDLE;
        endcase
    end

    assign counting = (state_q == RUN) || (state_q == LAP);
    assign tick_int = counting && (presc_q == PRESC_LAST);

    // Ripple the carry from hundredths upward; carry left set means 59:59.99 rolled over.
    always_comb begin
        digits_inc = digits_q;
        carry      = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (carry) begin
                if (digits_q[i] == DIGIT_MAX[i]) begin
                    digits_inc[i] = 4'd0;
                end else begin
                    digits_inc[i] = digits_q[i] + 4'd1;
                    carry         = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            digits_q   <= '0;
            snap_q     <= '0;
            running_q  <= 1'b0;
            lap_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            running_q  <= (state_d == RUN) || (state_d == LAP);
            lap_hold_q <= (state_d == LAP);

            if (clear)         presc_q <= '0;
            else if (counting) presc_q <= tick_int ? '0 : presc_q + 1'b1;

            if (clear)         digits_q <= '0;
            else if (tick_int) digits_q <= digits_inc;

            // Snapshot takes the pre-tick value when a tick lands in the lap cycle.
            if (clear)        snap_q <= '0;
            else if (capture) snap_q <= digits_q;
        end
    end

    assign bus.time_bcd = lap_hold_q ? snap_q : digits_q;
    assign bus.running  = running_q;
    assign bus.lap_hold = lap_hold_q;
    assign bus.tick     = tick_int;
    assign bus.wrap     = tick_int & carry;
endmodule

// File: doc/stopwatch_timebase.md
Name: stopwatch_timebase

Overview:
Time-base and control stage for the MM:SS.hh stopwatch. It debounces the run and lap pushbuttons and divides the system clock into a 1/100 s tick. It runs a run/pause/lap state machine and keeps the elapsed time as six cascaded BCD digits. The output bus feeds the per-digit 7-segment decoders directly, so no binary-to-BCD conversion is needed downstream.

Parameters:
TICK_DIV, 500000, clock cycles per 1/100 s tick (50 MHz / 100); minimum 2.
DEBOUNCE_CYCLES, 1000000, cycles a synchronised button level must stay stable before it is accepted (20 ms at 50 MHz); minimum 1.

Ports:
clock  input  1  system clock, CLOCK_50 at top level.
reset  input  1  asynchronous, active-high reset.
key_run_n  input  1  raw start/stop pushbutton, active-low, asynchronous to clock.
key_lap_n  input  1  raw lap/clear pushbutton, active-low, asynchronous to clock.
time_bcd  output  24  {min_tens, min_ones, sec_tens, sec_ones, hund_tens, hund_ones}, 4 bits each, BCD.
running  output  1  high in RUN and LAP states.
lap_hold  output  1  high in LAP state; time_bcd is frozen.
tick  output  1  one-cycle pulse on each counted 1/100 s.
wrap  output  1  one-cycle pulse when the count rolls over from 59:59.99 to 00:00.00.

Behaviour:
- Reset (asynchronous, high): state IDLE; all digits 0; snapshot 0; prescaler 0; debouncers hold the released level (1); all outputs 0, time_bcd = 0.
- Input conditioning: each key passes a 2-flop synchroniser, then a stability counter.
  - The accepted level changes only after the synchronised level differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any bounce restarts the count.
  - A press event is a one-cycle pulse when the accepted level goes 1 to 0. Release generates no event.
- States: IDLE, RUN, PAUSE, LAP.
  - run press: IDLE->RUN, RUN->PAUSE, PAUSE->RUN, LAP->PAUSE (the freeze is released, so PAUSE shows the live count).
  - lap press: RUN->LAP and snapshot captured; LAP->RUN and freeze released; PAUSE->IDLE with digits, prescaler and snapshot cleared; IDLE has no effect.
  - Run and lap press events in the same cycle: run wins and lap is discarded.
- Prescaler: counts 0..TICK_DIV-1 in RUN and LAP.
  - tick is asserted combinationally in the cycle the prescaler equals TICK_DIV-1; the prescaler then wraps to 0.
  - In PAUSE the prescaler holds its value, so resuming keeps the partial hundredth. It is cleared on entering IDLE.
- Digit counters: advance in the cycle tick is high, registered, visible the next cycle.
  - Ranges: hund_ones 0-9, hund_tens 0-9, sec_ones 0-9, sec_tens 0-5, min_ones 0-9, min_tens 0-5.
  - Each digit carries into the next when it wraps to 0.
  - When all digits are at their maximum (59:59.99), the next tick gives 00:00.00, wrap pulses in that same tick cycle, and counting continues.
  - Non-BCD values are unreachable; a digit never exceeds its range.
- time_bcd: shows the snapshot in LAP and the live digits otherwise.
  - The snapshot is the live digit value in the cycle the lap event is accepted, i.e. before any tick in that same cycle is applied. The live count keeps running underneath.
- running and lap_hold are registered decodes of the next state, valid the cycle after the event.
- Reset mid-count: returns to IDLE immediately, regardless of key levels. A key held through reset release gives no press until it is released and pressed again.

Test Plan:
All scenarios use TICK_DIV=4 and DEBOUNCE_CYCLES=3.
1. Reset, key_run_n low for 6 cycles -> one press event; running=1; tick every 4 cycles; after 12 ticks time_bcd=24'h000012.
2. key_run_n toggled each cycle for 10 cycles, then held high -> no press event; state stays IDLE; time_bcd=0.
3. RUN to 09.99, one more tick -> time_bcd=24'h001000; at 59:59.99 one tick -> 24'h000000 and wrap=1 for exactly 1 cycle.
4. RUN at 00:03.47, lap press -> lap_hold=1 and time_bcd held at 24'h000347 while running; after 10 further ticks, lap press -> time_bcd=24'h000357.
5. RUN, run press two cycles after a tick -> PAUSE, digits hold; resume -> next tick arrives after 2 cycles (prescaler preserved); run press then lap press in PAUSE -> IDLE, time_bcd=0.
6. Run and lap press events in the same cycle from IDLE -> RUN only, lap_hold=0; assert reset mid-RUN -> all outputs 0 asynchronously.
